pc_unit: RTL
============

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter W, default 16, PC width in bits.
REQ-002 Parameter STEP, default 2, sequential increment added per advance.
REQ-003 Parameter DEPTH, default 4, return-stack entries (DEPTH >= 1).
REQ-004 Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-005 clock  in  1  single clock; all state updates on posedge clock.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 stall  in  1  1 = hold all state this cycle.
REQ-008 op  in  2  00 INC, 01 JUMP, 10 CALL, 11 RET.
REQ-009 target  in  W  destination for JUMP/CALL.
REQ-010 pc  out  W  current program counter, registered.
REQ-011 depth  out  $clog2(DEPTH)+1  number of valid return-stack entries.
REQ-012 ovf  out  1  sticky return-stack overflow flag.
REQ-013 unf  out  1  sticky return-stack underflow flag.

Function
REQ-014 Priority per cycle SHALL be reset > stall > op.
REQ-015 stall=1 SHALL leave pc, stack, depth, ovf, unf unchanged regardless of op.
REQ-016 INC SHALL load pc <= (pc + STEP) mod 2^W; wrap from 2^W-STEP to 0 is legal and silent.
REQ-017 JUMP SHALL load pc <= target; stack untouched.
REQ-018 CALL with depth < DEPTH SHALL push (pc + STEP) mod 2^W, increment depth, load pc <= target, all in one cycle.
REQ-019 CALL with depth == DEPTH SHALL load pc <= target, discard the push, keep depth and stack contents, set ovf.
REQ-020 RET with depth > 0 SHALL load pc <= top-of-stack, decrement depth.
REQ-021 RET with depth == 0 SHALL load pc <= (pc + STEP) mod 2^W and set unf.
REQ-022 Stack SHALL be LIFO; top-of-stack is the most recently pushed, not yet popped entry.
REQ-023 Latency: every op SHALL be visible on pc exactly one clock after the sampling edge; no combinational path from inputs to outputs.
REQ-024 ovf and unf SHALL remain set until reset once set.
REQ-025 target SHALL be used without alignment checks; pc takes any W-bit value.

Reset
REQ-026 reset=1 at posedge SHALL set pc=RESET_PC, depth=0, ovf=0, unf=0; stack entry contents need not be cleared.
REQ-027 reset SHALL override stall and any op in the same cycle, including mid-sequence CALL/RET.
REQ-028 First op after reset deassertion SHALL act on pc=RESET_PC.

Configuration
REQ-029 Macro PC_STACK_EN SHALL compile the return stack in.
REQ-030 With PC_STACK_EN defined: behaviour per REQ-018..REQ-022, REQ-024.
REQ-031 Without PC_STACK_EN: no stack storage; CALL SHALL behave as JUMP; RET SHALL behave as INC; depth, ovf, unf SHALL be constant 0.

Verification
REQ-032 Reset then 4 INC, W=16, STEP=2 -> pc sequence 0,2,4,6,8.
REQ-033 pc=0xFFFE, INC -> pc=0x0000, ovf=0, unf=0.
REQ-034 pc=0x0010, CALL target=0x0100; INC; RET -> pc 0x0100, 0x0102, 0x0012; depth 1,1,0 (PC_STACK_EN).
REQ-035 DEPTH=4, 5 successive CALLs target=0x0200 from pc=0 -> depth saturates 4, ovf=1 after 5th, pc=0x0200; then 4 RETs return 0x0202,0x0202,0x0202,0x0002 order per LIFO pushes.
REQ-036 depth=0, RET at pc=0x0040 -> pc=0x0042, unf=1; later reset -> unf=0, pc=RESET_PC.
REQ-037 stall=1 with op=JUMP target=0x1234 for 3 cycles -> pc unchanged; stall=1 with reset=1 -> pc=RESET_PC.

Source files
------------

// File: rtl/pc_unit.sv
// Program counter with sequential increment, jump, and an optional LIFO return stack.
// Define PC_STACK_EN to build the return stack; otherwise CALL acts as JUMP and RET as INC.
module pc_unit #(
  parameter int W        = 16,
  parameter int STEP     = 2,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   stall,
  input  logic [1:0]             op,
  input  logic [W-1:0]           target,
  output logic [W-1:0]           pc,
  output logic [$clog2(DEPTH):0] depth,
  output logic                   ovf,
  output logic                   unf
);

  localparam int DW = $clog2(DEPTH) + 1;

  logic [W-1:0] pc_r;
  logic [W-1:0] pc_nxt_s;
  logic [W-1:0] seq_pc_s;

  assign seq_pc_s = pc_r + W'(STEP);
  assign pc       = pc_r;

`ifdef PC_STACK_EN
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  stack_r [DEPTH];
  logic [DW-1:0] depth_r;
  logic [DW-1:0] depth_nxt_s;
  logic          ovf_r;
  logic          ovf_nxt_s;
  logic          unf_r;
  logic          unf_nxt_s;
  logic          push_s;
  logic [AW-1:0] wr_idx_s;
  logic [AW-1:0] rd_idx_s;

  // depth_r counts valid entries, so it is the free slot and depth_r-1 is the top
  assign wr_idx_s = AW'(depth_r);
  assign rd_idx_s = AW'(depth_r - DW'(1));

  // Next-state decode of the op, including stack push/pop bookkeeping
  always_comb begin
    pc_nxt_s    = pc_r;
    depth_nxt_s = depth_r;
    ovf_nxt_s   = ovf_r;
    unf_nxt_s   = unf_r;
    push_s      = 1'b0;
    case (op)
      2'b00: pc_nxt_s = seq_pc_s;
      2'b01: pc_nxt_s = target;
      2'b10: begin
        pc_nxt_s = target;
        if (depth_r < DW'(DEPTH)) begin
          push_s      = 1'b1;
          depth_nxt_s = depth_r + DW'(1);
        end else begin
          ovf_nxt_s = 1'b1;
        end
      end
      2'b11: begin
        if (depth_r != DW'(0)) begin
          pc_nxt_s    = stack_r[rd_idx_s];
          depth_nxt_s = depth_r - DW'(1);
        end else begin
          pc_nxt_s  = seq_pc_s;
          unf_nxt_s = 1'b1;
        end
      end
      default: pc_nxt_s = pc_r;
    endcase
  end

  // Control state: reset overrides stall, stall freezes everything
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_r    <= W'(RESET_PC);
      depth_r <= {DW{1'b0}};
      ovf_r   <= 1'b0;
      unf_r   <= 1'b0;
    end else if (!stall) begin
      pc_r    <= pc_nxt_s;
      depth_r <= depth_nxt_s;
      ovf_r   <= ovf_nxt_s;
      unf_r   <= unf_nxt_s;
    end
  end

  // Stack storage; contents are left as-is on reset since depth_r marks validity
  always_ff @(posedge clock) begin
    if (!reset && !stall && push_s) begin
      stack_r[wr_idx_s] <= seq_pc_s;
    end
  end

  assign depth = depth_r;
  assign ovf   = ovf_r;
  assign unf   = unf_r;
`else
  // Next-pc decode without a stack: CALL jumps, RET steps
  always_comb begin
    pc_nxt_s = pc_r;
    case (op)
      2'b00:   pc_nxt_s = seq_pc_s;
      2'b01:   pc_nxt_s = target;
      2'b10:   pc_nxt_s = target;
      2'b11:   pc_nxt_s = seq_pc_s;
      default: pc_nxt_s = pc_r;
    endcase
  end

  // PC register: reset overrides stall
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_r <= W'(RESET_PC);
    end else if (!stall) begin
      pc_r <= pc_nxt_s;
    end
  end

  assign depth = {DW{1'b0}};
  assign ovf   = 1'b0;
  assign unf   = 1'b0;
`endif

endmodule
